multicycle_main_fsm: RTL and testbench
======================================

// Module: multicycle_main_fsm
// PURPOSE
//  Main controller FSM of the multicycle RV32I core; sits directly upstream of the ALU decoder and drives its aluOp input.
//  Decodes opcode, sequences fetch/decode/execute/memory/writeback and drives datapath mux selects and write enables.
//  Supports lw, sw, R-type, I-type ALU, beq and jal; every other opcode is flagged illegal.
// PARAMETERS
//  none; all encodings come from riscv_ctrl_pkg
// PORTS
//  clk          in   1  single clock, rising edge
//  rst_n        in   1  asynchronous reset, active-low
//  op           in   7  instr[6:0] from the instruction register
//  zero         in   1  ALU zero flag
//  mem_ready    in   1  memory completes the current access this cycle
//  mem_req      out  1  memory access requested (FETCH, MEMREAD, MEMWRITE)
//  pc_write     out  1  pc_update | (branch & zero)
//  adr_src      out  1  0 = PC, 1 = ALUOut
//  mem_write    out  1  store strobe
//  ir_write     out  1  instruction/OldPC register load
//  result_src   out  2  00 ALUOut, 01 Data, 10 ALUResult
//  alu_src_a    out  2  00 PC, 01 OldPC, 10 rs1 (A)
//  alu_src_b    out  2  00 rs2, 01 ImmExt, 10 constant 4
//  alu_op       out  2  00 add, 01 sub, 10 funct-decoded (to ALU decoder)
//  imm_src      out  2  I=00, S=01, B=10, J=11; combinational from op
//  reg_write    out  1  register-file write enable
//  illegal_instr out 1  one-cycle pulse in DECODE on an unsupported opcode
//  instr_done   out  1  one-cycle pulse on the last cycle of every instruction
// BEHAVIOUR
//  Clock and reset: one clock; reset is asynchronous and active-low.
//  Reset: state <= FETCH. While rst_n = 0, every enable (pc_write, ir_write, mem_write, reg_write, mem_req) and both pulses are 0.
//    Selects hold their FETCH values.
//  Outputs are Moore, decoded from the state register. Unlisted signals are 0.
//  FETCH:   mem_req; adr_src 0; srcA 00; srcB 10; alu_op 00; result 10.
//           ir_write and pc_update assert only in the mem_ready cycle. Stays in FETCH until mem_ready, then -> DECODE.
//  DECODE:  srcA 01; srcB 01; alu_op 00 (branch target into ALUOut). Next state by op:
//           lw/sw -> MEMADR; R -> EXEC_R; I -> EXEC_I; beq -> BEQ; jal -> JAL;
//           other -> FETCH with illegal_instr = 1 and instr_done = 0.
//  MEMADR:  srcA 10; srcB 01; alu_op 00. lw -> MEMREAD, sw -> MEMWRITE.
//  MEMREAD: mem_req; adr_src 1; result 00. Waits for mem_ready, then -> MEMWB.
//  MEMWRITE: mem_req; adr_src 1; result 00. mem_write is held until the mem_ready cycle, then -> FETCH with instr_done.
//  MEMWB:   result 01; reg_write; instr_done; -> FETCH.
//  EXEC_R:  srcA 10; srcB 00; alu_op 10; -> ALUWB.
//  EXEC_I:  srcA 10; srcB 01; alu_op 10; -> ALUWB.
//  ALUWB:   result 00; reg_write; instr_done; -> FETCH.
//  BEQ:     srcA 10; srcB 00; alu_op 01; result 00; branch; instr_done; -> FETCH.
//           pc_write = zero in this cycle.
//  JAL:     srcA 01; srcB 10; alu_op 00; result 00; pc_update; -> ALUWB. rd receives OldPC+4.
//  Latencies with mem_ready tied to 1: lw 5, sw 4, R/I 4, jal 4, beq 3 cycles.
//    Each mem_ready = 0 cycle adds 1.
//  op is sampled only in DECODE and MEMADR. The IR must stay stable, since ir_write = 0 outside FETCH.
//  Reset mid-instruction aborts immediately, with no partial write after rst_n falls.
//  Restart is from FETCH on the first clock edge after rst_n rises.
//  imm_src for an unsupported op: 00.
// STRUCTURE
//  riscv_ctrl_pkg holds:
//    opcode constants OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL
//    state localparams, 4-bit binary
//    encodings for result_src, alu_src_a, alu_src_b and alu_op
//  Sub-module imm_src_decoder: combinational op -> imm_src, shared with the single-cycle core.
//  The FSM is one state register plus next-state and output always blocks.
// TESTING
//  Reset: rst_n low mid-MEMWRITE -> mem_write 0 at once; after release, state FETCH and ir_write on the first mem_ready.
//  lw, mem_ready = 1: states FETCH, DECODE, MEMADR, MEMREAD, MEMWB.
//    reg_write = 1 and result_src = 01 in cycle 5; instr_done once.
//  beq: zero = 1 -> pc_write = 1 in the BEQ cycle; zero = 0 -> pc_write = 0. alu_op = 01 in both.
//  Memory stall: mem_ready = 0 for 3 cycles in FETCH -> ir_write stays 0, state stays FETCH.
//    ir_write = 1 exactly in the 4th cycle.
//  op = 7'b1111111: illegal_instr pulses in DECODE; next state FETCH; no reg_write or mem_write.
//  R-type then jal back to back: alu_op = 10 in EXEC_R.
//    JAL: srcA 01, srcB 10, pc_write 1; then ALUWB with reg_write.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: opcodes, FSM states and datapath select encodings for the RV32I controllers
package riscv_ctrl_pkg;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWRITE = 4'd4,
      S_MEMWB    = 4'd5,
      S_EXEC_R   = 4'd6,
      S_EXEC_I   = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10
   } state_t;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   function automatic logic op_legal(input logic [6:0] op);
      return op == OP_LW || op == OP_SW || op == OP_R || op == OP_I || op == OP_BEQ || op == OP_JAL;
   endfunction

endpackage

// File: rtl/multicycle_main_fsm_if.sv
// multicycle_main_fsm_if: controller <-> datapath signal bundle
interface multicycle_main_fsm_if;
   logic [6:0] op;
   logic       zero;
   logic       mem_ready;
   logic       mem_req;
   logic       pc_write;
   logic       adr_src;
   logic       mem_write;
   logic       ir_write;
   logic [1:0] result_src;
   logic [1:0] alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] alu_op;
   logic [1:0] imm_src;
   logic       reg_write;
   logic       illegal_instr;
   logic       instr_done;

   modport master (
      input  op, zero, mem_ready,
      output mem_req, pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
             alu_src_b, alu_op, imm_src, reg_write, illegal_instr, instr_done
   );

   modport slave (
      output op, zero, mem_ready,
      input  mem_req, pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
             alu_src_b, alu_op, imm_src, reg_write, illegal_instr, instr_done
   );
endinterface

// File: rtl/imm_src_decoder.sv
// imm_src_decoder: opcode -> immediate format select, unsupported opcodes map to I
module imm_src_decoder (
   input  logic [6:0] op,
   output logic [1:0] imm_src
);
   import riscv_ctrl_pkg::*;

   // immediate format is a pure function of the opcode
   always_comb
      imm_src = op == OP_SW  ? IMM_S :
                op == OP_BEQ ? IMM_B :
                op == OP_JAL ? IMM_J : IMM_I;
endmodule

// File: rtl/multicycle_main_fsm.sv
// multicycle_main_fsm: main sequencing controller of the multicycle RV32I core
module multicycle_main_fsm (
   input logic                   clk,
   input logic                   rst_n,
   multicycle_main_fsm_if.master bus
);
   import riscv_ctrl_pkg::*;

   state_t     state;
   state_t     next_state;
   logic       pc_update;
   logic       branch;
   logic       adr_src;
   logic       mem_write;
   logic       ir_write;
   logic       reg_write;
   logic       mem_req;
   logic       illegal;
   logic       done;
   logic [1:0] result_src;
   logic [1:0] alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] alu_op;
   logic [1:0] imm_src;

   imm_src_decoder u_imm (
      .op      (bus.op),
      .imm_src (imm_src)
   );

   // state register, reset drops straight back to FETCH
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= S_FETCH;
      else        state <= next_state;

   // next-state: op matters only in DECODE and MEMADR, memory states wait on mem_ready
   always_comb begin
      next_state = S_FETCH;
      case (state)
         S_FETCH:    next_state = bus.mem_ready ? S_DECODE : S_FETCH;
         S_DECODE:   next_state = (bus.op == OP_LW || bus.op == OP_SW) ? S_MEMADR :
                                  bus.op == OP_R   ? S_EXEC_R :
                                  bus.op == OP_I   ? S_EXEC_I :
                                  bus.op == OP_BEQ ? S_BEQ    :
                                  bus.op == OP_JAL ? S_JAL    : S_FETCH;
         S_MEMADR:   next_state = bus.op == OP_LW ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  next_state = bus.mem_ready ? S_MEMWB : S_MEMREAD;
         S_MEMWRITE: next_state = bus.mem_ready ? S_FETCH : S_MEMWRITE;
         S_EXEC_R:   next_state = S_ALUWB;
         S_EXEC_I:   next_state = S_ALUWB;
         S_JAL:      next_state = S_ALUWB;
         default:    next_state = S_FETCH;
      endcase
   end

   // Moore outputs from state; only memory handshakes and the illegal flag look at inputs
   always_comb begin
      pc_update  = 1'b0;
      branch     = 1'b0;
      adr_src    = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      mem_req    = 1'b0;
      illegal    = 1'b0;
      done       = 1'b0;
      result_src = RES_ALUOUT;
      alu_src_a  = SRCA_PC;
      alu_src_b  = SRCB_RS2;
      alu_op     = ALUOP_ADD;
      case (state)
         S_FETCH: begin
            mem_req    = 1'b1;
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALURESULT;
            ir_write   = bus.mem_ready;
            pc_update  = bus.mem_ready;
         end
         S_DECODE: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
            illegal   = !op_legal(bus.op);
         end
         S_MEMADR: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
         end
         S_MEMREAD: begin
            mem_req = 1'b1;
            adr_src = 1'b1;
         end
         S_MEMWRITE: begin
            mem_req   = 1'b1;
            adr_src   = 1'b1;
            mem_write = 1'b1;
            done      = bus.mem_ready;
         end
         S_MEMWB: begin
            result_src = RES_DATA;
            reg_write  = 1'b1;
            done       = 1'b1;
         end
         S_EXEC_R: begin
            alu_src_a = SRCA_RS1;
            alu_op    = ALUOP_FUNCT;
         end
         S_EXEC_I: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            alu_op    = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            reg_write = 1'b1;
            done      = 1'b1;
         end
         S_BEQ: begin
            alu_src_a = SRCA_RS1;
            alu_op    = ALUOP_SUB;
            branch    = 1'b1;
            done      = 1'b1;
         end
         S_JAL: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_FOUR;
            pc_update = 1'b1;
         end
         default: ;
      endcase
   end

   // enables and pulses are forced low while reset is held, so an abort leaves no partial write
   assign bus.pc_write      = rst_n & (pc_update | (branch & bus.zero));
   assign bus.ir_write      = rst_n & ir_write;
   assign bus.mem_write     = rst_n & mem_write;
   assign bus.reg_write     = rst_n & reg_write;
   assign bus.mem_req       = rst_n & mem_req;
   assign bus.illegal_instr = rst_n & illegal;
   assign bus.instr_done    = rst_n & done;
   assign bus.adr_src       = adr_src;
   assign bus.result_src    = result_src;
   assign bus.alu_src_a     = alu_src_a;
   assign bus.alu_src_b     = alu_src_b;
   assign bus.alu_op        = alu_op;
   assign bus.imm_src       = imm_src;
endmodule

// File: tb/tb_multicycle_main_fsm.sv
// tb_multicycle_main_fsm: directed sequences through the main controller FSM
module tb_multicycle_main_fsm;
   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_bad = 0;

   multicycle_main_fsm_if bus ();

   multicycle_main_fsm dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.op        = 7'b0000011;
      bus.zero      = 1'b0;
      bus.mem_ready = 1'b1;
      #3;
      chk("rst_state", 32'(dut.state), 0);
      chk("rst_mem_req", 32'(bus.mem_req), 0);
      chk("rst_ir_write", 32'(bus.ir_write), 0);
      chk("rst_pc_write", 32'(bus.pc_write), 0);
      chk("rst_src_b", 32'(bus.alu_src_b), 2);
      #4 rst_n = 1'b1;
      #1;
      chk("rel_ir_write", 32'(bus.ir_write), 1);
      chk("rel_pc_write", 32'(bus.pc_write), 1);
      // lw with memory always ready
      tick(); #1;
      chk("lw_dec_state", 32'(dut.state), 1);
      chk("lw_dec_src_a", 32'(bus.alu_src_a), 1);
      chk("lw_dec_imm", 32'(bus.imm_src), 0);
      tick(); #1;
      chk("lw_adr_state", 32'(dut.state), 2);
      chk("lw_adr_src_a", 32'(bus.alu_src_a), 2);
      tick(); #1;
      chk("lw_rd_state", 32'(dut.state), 3);
      chk("lw_rd_adr", 32'(bus.adr_src), 1);
      chk("lw_rd_done", 32'(bus.instr_done), 0);
      tick(); #1;
      chk("lw_wb_state", 32'(dut.state), 5);
      chk("lw_wb_reg_write", 32'(bus.reg_write), 1);
      chk("lw_wb_result", 32'(bus.result_src), 1);
      chk("lw_wb_done", 32'(bus.instr_done), 1);
      tick(); #1;
      chk("lw_end_state", 32'(dut.state), 0);
      // beq taken then not taken
      bus.op = 7'b1100011;
      tick(); #1;
      chk("beq_imm", 32'(bus.imm_src), 2);
      tick(); bus.zero = 1'b1; #1;
      chk("beq1_state", 32'(dut.state), 9);
      chk("beq1_pc_write", 32'(bus.pc_write), 1);
      chk("beq1_alu_op", 32'(bus.alu_op), 1);
      chk("beq1_done", 32'(bus.instr_done), 1);
      tick(); bus.zero = 1'b0; #1;
      chk("beq_back_fetch", 32'(dut.state), 0);
      tick(); tick(); #1;
      chk("beq0_state", 32'(dut.state), 9);
      chk("beq0_pc_write", 32'(bus.pc_write), 0);
      chk("beq0_alu_op", 32'(bus.alu_op), 1);
      tick();
      // fetch stall of three cycles, then an illegal opcode
      bus.op = 7'b1111111;
      bus.mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stall_state", 32'(dut.state), 0);
         chk("stall_ir_write", 32'(bus.ir_write), 0);
         chk("stall_mem_req", 32'(bus.mem_req), 1);
         tick();
      end
      bus.mem_ready = 1'b1; #1;
      chk("stall_ir_write4", 32'(bus.ir_write), 1);
      tick(); #1;
      chk("ill_state", 32'(dut.state), 1);
      chk("ill_pulse", 32'(bus.illegal_instr), 1);
      chk("ill_done", 32'(bus.instr_done), 0);
      chk("ill_reg_write", 32'(bus.reg_write), 0);
      chk("ill_mem_write", 32'(bus.mem_write), 0);
      chk("ill_imm", 32'(bus.imm_src), 0);
      tick(); #1;
      chk("ill_next", 32'(dut.state), 0);
      chk("ill_clear", 32'(bus.illegal_instr), 0);
      // R-type then jal back to back
      bus.op = 7'b0110011;
      tick(); tick(); #1;
      chk("r_state", 32'(dut.state), 6);
      chk("r_alu_op", 32'(bus.alu_op), 2);
      chk("r_src_b", 32'(bus.alu_src_b), 0);
      tick(); #1;
      chk("r_wb_state", 32'(dut.state), 8);
      chk("r_wb_reg_write", 32'(bus.reg_write), 1);
      chk("r_wb_done", 32'(bus.instr_done), 1);
      tick(); bus.op = 7'b1101111; #1;
      chk("jal_fetch", 32'(dut.state), 0);
      tick(); #1;
      chk("jal_imm", 32'(bus.imm_src), 3);
      tick(); #1;
      chk("jal_state", 32'(dut.state), 10);
      chk("jal_src_a", 32'(bus.alu_src_a), 1);
      chk("jal_src_b", 32'(bus.alu_src_b), 2);
      chk("jal_pc_write", 32'(bus.pc_write), 1);
      chk("jal_reg_write", 32'(bus.reg_write), 0);
      tick(); #1;
      chk("jal_wb_state", 32'(dut.state), 8);
      chk("jal_wb_reg_write", 32'(bus.reg_write), 1);
      tick();
      // I-type passes through EXEC_I
      bus.op = 7'b0010011;
      tick(); tick(); #1;
      chk("i_state", 32'(dut.state), 7);
      chk("i_src_b", 32'(bus.alu_src_b), 1);
      tick(); tick();
      // sw stalled in MEMWRITE, then aborted by reset
      bus.op = 7'b0100011;
      tick(); #1;
      chk("sw_imm", 32'(bus.imm_src), 1);
      tick(); tick(); bus.mem_ready = 1'b0; #1;
      chk("sw_state", 32'(dut.state), 4);
      chk("sw_mem_write", 32'(bus.mem_write), 1);
      chk("sw_done_wait", 32'(bus.instr_done), 0);
      tick(); #1;
      chk("sw_hold", 32'(dut.state), 4);
      rst_n = 1'b0; #1;
      chk("abort_mem_write", 32'(bus.mem_write), 0);
      chk("abort_mem_req", 32'(bus.mem_req), 0);
      chk("abort_state", 32'(dut.state), 0);
      tick(); #2;
      rst_n = 1'b1;
      bus.mem_ready = 1'b1; #1;
      chk("restart_state", 32'(dut.state), 0);
      chk("restart_ir_write", 32'(bus.ir_write), 1);
      // complete sw with memory ready
      tick(); tick(); tick(); #1;
      chk("sw2_state", 32'(dut.state), 4);
      chk("sw2_done", 32'(bus.instr_done), 1);
      tick(); #1;
      chk("sw2_end", 32'(dut.state), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
